// File: rtl/grant_burst_ctrl.sv
// Burst controller behind a 3-way round-robin arbiter: latches the one-hot grant
// owner, streams that requester's beats over one valid/ready channel, then pulses done.
module grant_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          grant,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [3*LEN_W-1:0]  req_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          ack,
  output logic [2:0]          done,
  output logic                busy,
  output logic [1:0]          owner,
  output logic                err_multi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_owner;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;
  logic [1:0]       w_grant_idx;
  logic             w_multi;
  logic [LEN_W-1:0] w_len_sel;
  logic             w_last;
  logic             w_valid;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Lowest-index priority so a malformed multi-bit grant still resolves deterministically.
  always_comb begin
    w_grant_idx = 2'd0;
    if (grant[0]) begin
      w_grant_idx = 2'd0;
    end else if (grant[1]) begin
      w_grant_idx = 2'd1;
    end else if (grant[2]) begin
      w_grant_idx = 2'd2;
    end else begin
      w_grant_idx = 2'd0;
    end
    w_multi = (grant[0] & grant[1]) | (grant[0] & grant[2]) | (grant[1] & grant[2]);
    case (w_grant_idx)
      2'd0:    w_len_sel = req_len[0*LEN_W +: LEN_W];
      2'd1:    w_len_sel = req_len[1*LEN_W +: LEN_W];
      2'd2:    w_len_sel = req_len[2*LEN_W +: LEN_W];
      default: w_len_sel = {LEN_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    w_last = (r_cnt == r_len);
    case (r_state)
      ST_IDLE: begin
        if (grant != 3'b000) begin
          w_next = ST_XFER;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (out_ready && w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_XFER;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Compare precedes increment, so an all-ones length yields 2^LEN_W beats without wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 2'd0;
      r_len   <= {LEN_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (grant != 3'b000) begin
            r_owner <= w_grant_idx;
            r_len   <= w_len_sel;
            r_cnt   <= {LEN_W{1'b0}};
            if (w_multi) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (out_ready && !w_last) begin
            r_cnt <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: r_owner <= 2'd0;
        default: begin
          r_owner <= 2'd0;
          r_cnt   <= {LEN_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake outputs are gated by rst so nothing leaks while a burst is being abandoned.
  always_comb begin
    w_valid   = (r_state == ST_XFER) && !rst;
    out_valid = w_valid;
    busy      = (r_state == ST_XFER) || (r_state == ST_DONE);
    owner     = r_owner;
    err_multi = r_err;
    if (w_valid && out_ready) begin
      ack = idx_to_onehot(r_owner);
    end else begin
      ack = 3'b000;
    end
    if ((r_state == ST_DONE) && !rst) begin
      done = idx_to_onehot(r_owner);
    end else begin
      done = 3'b000;
    end
    case (r_owner)
      2'd0:    out_data = req_data[0*DATA_W +: DATA_W];
      2'd1:    out_data = req_data[1*DATA_W +: DATA_W];
      2'd2:    out_data = req_data[2*DATA_W +: DATA_W];
      default: out_data = {DATA_W{1'b0}};
    endcase
  end

endmodule
